// File: rtl/sequence_checker.sv
// Checks a player's debounced button presses against a stored colour sequence,
// reporting a one-cycle pass or fail pulse at the end of each attempt.
module sequence_checker #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [5:0]  round_len,
  input  logic [95:0] segment,
  input  logic [3:0]  buttons,
  output logic [3:0]  player_input,
  output logic [4:0]  check_round,
  output logic        busy,
  output logic        pass,
  output logic        fail
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_PRESS,
    WAIT_RELEASE
  } state_t;

  localparam logic [7:0]  DEB_LAST = 8'(DEBOUNCE_CYCLES - 1);
  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);

  logic [3:0]  sync1_q, sync1_d;
  logic [3:0]  sync2_q, sync2_d;
  logic [3:0]  prev_q, prev_d;
  logic [7:0]  deb_cnt_q, deb_cnt_d;
  logic [3:0]  player_input_q, player_input_d;

  state_t      state_q, state_d;
  logic [4:0]  check_round_q, check_round_d;
  logic [15:0] timer_q, timer_d;
  logic [5:0]  len_q, len_d;
  logic [3:0]  held_q, held_d;
  logic        busy_q, busy_d;
  logic        pass_q, pass_d;
  logic        fail_q, fail_d;

  logic        press_any;
  logic        press_multi;
  logic [1:0]  press_code;
  logic [2:0]  seg_cur;
  logic        press_match;
  logic        last_entry;
  logic        start_ok;

  // deb_cnt holds (run length - 1) of the current synchronised value, saturating
  // at DEB_LAST; the vector is accepted whenever the run is long enough.
  always_comb begin
    sync1_d   = buttons;
    sync2_d   = sync1_q;
    prev_d    = sync2_q;
    deb_cnt_d = deb_cnt_q;
    if (sync2_q != prev_q) begin
      deb_cnt_d = 8'd0;
    end else if (deb_cnt_q != DEB_LAST) begin
      deb_cnt_d = deb_cnt_q + 8'd1;
    end
    player_input_d = player_input_q;
    if (deb_cnt_d == DEB_LAST) begin
      player_input_d = sync2_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q        <= '0;
      sync2_q        <= '0;
      prev_q         <= '0;
      deb_cnt_q      <= '0;
      player_input_q <= '0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      prev_q         <= prev_d;
      deb_cnt_q      <= deb_cnt_d;
      player_input_q <= player_input_d;
    end
  end

  always_comb begin
    press_any   = (player_input_q != 4'd0);
    press_multi = ((player_input_q & (player_input_q - 4'd1)) != 4'd0);
    press_code  = 2'd0;
    case (player_input_q)
      4'b0010: press_code = 2'd1;
      4'b0100: press_code = 2'd2;
      4'b1000: press_code = 2'd3;
      default: press_code = 2'd0;
    endcase
    seg_cur = 3'b000;
    for (int i = 0; i < 32; i++) begin
      if (check_round_q == 5'(i)) begin
        seg_cur = segment[3*i +: 3];
      end
    end
    // A leading zero bit keeps codes 3'b1xx from ever matching a press.
    press_match = press_any && !press_multi && ({1'b0, press_code} == seg_cur);
    last_entry  = ({1'b0, check_round_q} == (len_q - 6'd1));
    start_ok    = start && (round_len != 6'd0) && (round_len <= 6'd32);
  end

  always_comb begin
    state_d       = state_q;
    check_round_d = check_round_q;
    timer_d       = timer_q;
    len_d         = len_q;
    held_d        = held_q;
    pass_d        = 1'b0;
    fail_d        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          state_d       = WAIT_PRESS;
          check_round_d = 5'd0;
          timer_d       = 16'd0;
          len_d         = round_len;
        end
      end
      WAIT_PRESS: begin
        if (!press_any) begin
          if (timer_q == TO_LAST) begin
            fail_d  = 1'b1;
            state_d = IDLE;
          end else begin
            timer_d = timer_q + 16'd1;
          end
        end else if (press_match) begin
          state_d = WAIT_RELEASE;
          held_d  = player_input_q;
        end else begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_RELEASE: begin
        if ((player_input_q & ~held_q) != 4'd0) begin
          fail_d  = 1'b1;
          state_d = IDLE;
        end else if (!press_any) begin
          if (last_entry) begin
            pass_d  = 1'b1;
            state_d = IDLE;
          end else begin
            check_round_d = check_round_q + 5'd1;
            timer_d       = 16'd0;
            state_d       = WAIT_PRESS;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      check_round_q <= '0;
      timer_q       <= '0;
      len_q         <= '0;
      held_q        <= '0;
      busy_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      check_round_q <= check_round_d;
      timer_q       <= timer_d;
      len_q         <= len_d;
      held_q        <= held_d;
      busy_q        <= busy_d;
      pass_q        <= pass_d;
      fail_q        <= fail_d;
    end
  end

  assign player_input = player_input_q;
  assign check_round  = check_round_q;
  assign busy         = busy_q;
  assign pass         = pass_q;
  assign fail         = fail_q;

endmodule

// File: tb/tb_sequence_checker.sv
// Directed bench for sequence_checker: one instance with default timing and a
// second with a short timeout for the timeout and multi-press cases.
module tb_sequence_checker;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [5:0]  round_len;
  logic [95:0] segment;
  logic [3:0]  buttons;
  logic [3:0]  player_input;
  logic [4:0]  check_round;
  logic        busy;
  logic        pass;
  logic        fail;

  logic        start_t;
  logic [3:0]  buttons_t;
  logic [3:0]  player_input_t;
  logic [4:0]  check_round_t;
  logic        busy_t;
  logic        pass_t;
  logic        fail_t;

  int checks;
  int errors;
  int pass_seen;
  int fail_seen;
  int both_seen;
  int pass_base;
  int fail_base;

  sequence_checker #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(1000)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start),
    .round_len    (round_len),
    .segment      (segment),
    .buttons      (buttons),
    .player_input (player_input),
    .check_round  (check_round),
    .busy         (busy),
    .pass         (pass),
    .fail         (fail)
  );

  sequence_checker #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(20)) dut_to (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start_t),
    .round_len    (round_len),
    .segment      (segment),
    .buttons      (buttons_t),
    .player_input (player_input_t),
    .check_round  (check_round_t),
    .busy         (busy_t),
    .pass         (pass_t),
    .fail         (fail_t)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count pulses on the main instance mid-cycle so whole-run totals can be checked.
  initial begin
    pass_seen = 0;
    fail_seen = 0;
    both_seen = 0;
  end

  always @(negedge clk) begin
    if (pass === 1'b1) pass_seen++;
    if (fail === 1'b1) fail_seen++;
    if (pass === 1'b1 && fail === 1'b1) both_seen++;
  end

  // Advance n rising edges and land 1 time unit after the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] b);
    buttons = b;
  endtask

  task automatic pulseStart(input logic [5:0] len);
    round_len = len;
    start     = 1'b1;
    step(1);
    start     = 1'b0;
  endtask

  task automatic pressRelease(input logic [3:0] b);
    applyStimulus(b);
    step(10);
    applyStimulus(4'b0000);
    step(10);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    reset_n   = 1'b0;
    start     = 1'b0;
    start_t   = 1'b0;
    round_len = 6'd0;
    segment   = '0;
    buttons   = 4'b0000;
    buttons_t = 4'b0000;

    // Reset state of both instances.
    step(3);
    reset_n = 1'b1;
    checkOutput("reset_player_input", 32'(player_input), 32'h0);
    checkOutput("reset_check_round", 32'(check_round), 32'h0);
    checkOutput("reset_busy", 32'(busy), 32'h0);
    checkOutput("reset_pass", 32'(pass), 32'h0);
    checkOutput("reset_fail", 32'(fail), 32'h0);
    checkOutput("reset_busy_t", 32'(busy_t), 32'h0);
    step(6);

    // Timeout: fail arrives 20 edges after the start edge, not 19.
    round_len = 6'd3;
    start_t   = 1'b1;
    step(1);
    start_t   = 1'b0;
    checkOutput("to_busy", 32'(busy_t), 32'h1);
    checkOutput("to_round", 32'(check_round_t), 32'h0);
    step(19);
    checkOutput("to_fail_early", 32'(fail_t), 32'h0);
    step(1);
    checkOutput("to_fail", 32'(fail_t), 32'h1);
    checkOutput("to_busy_low", 32'(busy_t), 32'h0);
    checkOutput("to_no_pass", 32'(pass_t), 32'h0);
    step(1);
    checkOutput("to_fail_one_cycle", 32'(fail_t), 32'h0);

    // Two buttons at once on the short-timeout instance.
    start_t   = 1'b1;
    step(1);
    start_t   = 1'b0;
    buttons_t = 4'b0011;
    step(6);
    checkOutput("multi_pi", 32'(player_input_t), 32'h3);
    checkOutput("multi_fail_early", 32'(fail_t), 32'h0);
    step(1);
    checkOutput("multi_fail", 32'(fail_t), 32'h1);
    buttons_t = 4'b0000;
    step(10);

    // Correct three-entry pass: codes 000, 011, 001.
    segment       = '0;
    segment[5:3]  = 3'b011;
    segment[8:6]  = 3'b001;
    pass_base     = pass_seen;
    fail_base     = fail_seen;
    pulseStart(6'd3);
    checkOutput("p1_busy", 32'(busy), 32'h1);
    checkOutput("p1_round0", 32'(check_round), 32'h0);
    applyStimulus(4'b0001);
    step(5);
    checkOutput("deb_latency_early", 32'(player_input), 32'h0);
    step(1);
    checkOutput("deb_latency", 32'(player_input), 32'h1);
    step(4);
    applyStimulus(4'b0000);
    step(10);
    checkOutput("p1_round1", 32'(check_round), 32'h1);
    pulseStart(6'd3);
    checkOutput("busy_start_ignored", 32'(check_round), 32'h1);
    pressRelease(4'b1000);
    checkOutput("p1_round2", 32'(check_round), 32'h2);
    applyStimulus(4'b0010);
    step(10);
    applyStimulus(4'b0000);
    step(6);
    checkOutput("p1_pi_released", 32'(player_input), 32'h0);
    checkOutput("p1_pass_early", 32'(pass), 32'h0);
    step(1);
    checkOutput("p1_pass", 32'(pass), 32'h1);
    checkOutput("p1_busy_low", 32'(busy), 32'h0);
    checkOutput("p1_fail_low", 32'(fail), 32'h0);
    step(1);
    checkOutput("p1_pass_one_cycle", 32'(pass), 32'h0);
    checkOutput("p1_round_hold", 32'(check_round), 32'h2);
    checkOutput("p1_pass_count", 32'(pass_seen - pass_base), 32'h1);
    checkOutput("p1_fail_count", 32'(fail_seen - fail_base), 32'h0);
    step(4);

    // Wrong second colour: bit2 (code 010) against entry 011.
    pass_base = pass_seen;
    fail_base = fail_seen;
    pulseStart(6'd3);
    pressRelease(4'b0001);
    checkOutput("p2_round1", 32'(check_round), 32'h1);
    applyStimulus(4'b0100);
    step(6);
    checkOutput("p2_pi", 32'(player_input), 32'h4);
    checkOutput("p2_fail_early", 32'(fail), 32'h0);
    step(1);
    checkOutput("p2_fail", 32'(fail), 32'h1);
    step(1);
    checkOutput("p2_fail_one_cycle", 32'(fail), 32'h0);
    checkOutput("p2_busy_low", 32'(busy), 32'h0);
    applyStimulus(4'b0000);
    step(10);
    checkOutput("p2_pass_count", 32'(pass_seen - pass_base), 32'h0);
    checkOutput("p2_fail_count", 32'(fail_seen - fail_base), 32'h1);

    // Bouncing bit0: toggling every 2 cycles never settles long enough.
    fail_base = fail_seen;
    pulseStart(6'd3);
    for (int i = 0; i < 10; i++) begin
      applyStimulus(buttons ^ 4'b0001);
      step(2);
      checkOutput("bounce_pi", 32'(player_input), 32'h0);
    end
    step(6);
    checkOutput("bounce_pi_final", 32'(player_input), 32'h0);
    checkOutput("bounce_busy", 32'(busy), 32'h1);
    checkOutput("bounce_round", 32'(check_round), 32'h0);
    checkOutput("bounce_fail_count", 32'(fail_seen - fail_base), 32'h0);

    // Reset in WAIT_RELEASE at entry 1 clears everything without a pulse.
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(2);
    pass_base = pass_seen;
    fail_base = fail_seen;
    pulseStart(6'd3);
    pressRelease(4'b0001);
    applyStimulus(4'b1000);
    step(8);
    checkOutput("rst_pre_pi", 32'(player_input), 32'h8);
    checkOutput("rst_pre_round", 32'(check_round), 32'h1);
    checkOutput("rst_pre_busy", 32'(busy), 32'h1);
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("rst_async_pi", 32'(player_input), 32'h0);
    checkOutput("rst_async_round", 32'(check_round), 32'h0);
    checkOutput("rst_async_busy", 32'(busy), 32'h0);
    checkOutput("rst_async_pass", 32'(pass), 32'h0);
    checkOutput("rst_async_fail", 32'(fail), 32'h0);
    applyStimulus(4'b0000);
    step(1);
    reset_n = 1'b1;
    step(10);
    applyStimulus(4'b0001);
    step(10);
    checkOutput("no_start_busy", 32'(busy), 32'h0);
    applyStimulus(4'b0000);
    step(10);
    pulseStart(6'd0);
    checkOutput("len0_busy", 32'(busy), 32'h0);
    step(2);
    checkOutput("len0_busy_later", 32'(busy), 32'h0);
    pulseStart(6'd33);
    step(2);
    checkOutput("len33_busy", 32'(busy), 32'h0);
    checkOutput("rst_pass_count", 32'(pass_seen - pass_base), 32'h0);
    checkOutput("rst_fail_count", 32'(fail_seen - fail_base), 32'h0);

    // Full 32-entry round, every entry code 010 (bit2).
    segment   = {32{3'b010}};
    pass_base = pass_seen;
    fail_base = fail_seen;
    pulseStart(6'd32);
    for (int i = 0; i < 31; i++) begin
      pressRelease(4'b0100);
      checkOutput("full_round", 32'(check_round), 32'(i + 1));
    end
    applyStimulus(4'b0100);
    step(10);
    applyStimulus(4'b0000);
    step(6);
    checkOutput("full_round31", 32'(check_round), 32'd31);
    checkOutput("full_pass_early", 32'(pass), 32'h0);
    step(1);
    checkOutput("full_pass", 32'(pass), 32'h1);
    checkOutput("full_busy_low", 32'(busy), 32'h0);
    step(1);
    checkOutput("full_pass_one_cycle", 32'(pass), 32'h0);
    checkOutput("full_pass_count", 32'(pass_seen - pass_base), 32'h1);
    checkOutput("full_fail_count", 32'(fail_seen - fail_base), 32'h0);

    checkOutput("pass_fail_together", 32'(both_seen), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sequence_checker.md
SEQUENCE_CHECKER -- requirements
Module: sequence_checker

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive cycles the synchronised button vector must hold before it is accepted (range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 1000: cycles allowed in WAIT_PRESS before a fail (range 1..65535).
REQ-003 clk  input  1  single clock for the block; all state updates on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  one-cycle request to begin checking a player pass.
REQ-006 round_len  input  6  number of sequence entries to check; valid range 1..32.
REQ-007 segment  input  32x3  stored colour sequence; entry i is segment[i].
REQ-008 buttons  input  4  raw, asynchronous player buttons, one per colour.
REQ-009 player_input  output  4  debounced button vector, feeding the display block.
REQ-010 check_round  output  5  index of the entry currently being checked.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 pass  output  1  one-cycle pulse: whole sequence entered correctly.
REQ-013 fail  output  1  one-cycle pulse: wrong, multiple or late press.

Function
REQ-014 buttons SHALL pass through a 2-flop synchroniser before any other use.
REQ-015 The debounce counter SHALL reset to 0 whenever the synchronised vector differs from the previous cycle's value.
REQ-016 player_input SHALL take the synchronised value once it has been stable for DEBOUNCE_CYCLES cycles.
REQ-017 Debounce latency: a raw change held constant appears on player_input exactly 2+DEBOUNCE_CYCLES cycles later.
REQ-018 Colour encoding: buttons bit 0->3'b000, bit 1->3'b001, bit 2->3'b010, bit 3->3'b011; segment values 3'b1xx never match any press.
REQ-019 FSM states: IDLE, WAIT_PRESS, WAIT_RELEASE.
REQ-020 IDLE: start=1 with round_len in 1..32 -> WAIT_PRESS, check_round=0, timeout counter=0.
REQ-021 IDLE: start with round_len=0 or >32 SHALL be ignored, with no pulse issued.
REQ-022 start in any state other than IDLE SHALL be ignored.
REQ-023 WAIT_PRESS, player_input==0: the timeout counter increments each cycle.
REQ-024 WAIT_PRESS, counter reaches TIMEOUT_CYCLES-1 with no press: fail pulses next cycle -> IDLE.
REQ-025 WAIT_PRESS, player_input one-hot whose code equals segment[check_round] -> WAIT_RELEASE.
REQ-026 WAIT_PRESS, player_input one-hot but mismatched, or player_input with 2+ bits set -> fail pulse -> IDLE.
REQ-027 WAIT_RELEASE: no timeout applies; the FSM waits until player_input==0.
REQ-028 WAIT_RELEASE: if a second bit sets while the first is still held -> fail pulse -> IDLE.
REQ-029 WAIT_RELEASE, release with check_round==round_len-1 -> pass pulse -> IDLE.
REQ-030 WAIT_RELEASE, any other release -> check_round+1, timeout counter cleared -> WAIT_PRESS.
REQ-031 pass and fail SHALL be registered, SHALL last exactly one cycle, and SHALL never be asserted together.
REQ-032 check_round SHALL hold its last value in IDLE until the next accepted start.
REQ-033 round_len=32: check_round SHALL advance to 31 without wrap, and the final release SHALL produce pass.

Reset
REQ-034 reset_n low SHALL immediately clear the FSM (to IDLE), synchroniser, debounce counter, timeout counter, player_input, check_round, busy, pass and fail to 0.
REQ-035 Reset asserted mid-pass SHALL abort the pass with no pass or fail pulse.
REQ-036 After reset is released, the block SHALL need a new start before it checks any input.

Verification
REQ-037 segment[0..2]={000,011,001}, round_len=3, start, then press and release bit0, bit3, bit1 (each held 10 cycles) -> check_round steps 0,1,2; single pass pulse; fail never asserted.
REQ-038 Same setup, second press is bit2 -> fail pulse 1 cycle after player_input=4'b0100; busy low next cycle; pass never asserted.
REQ-039 Raw bit0 toggles every 2 cycles for 20 cycles with DEBOUNCE_CYCLES=4 -> player_input stays 0 and the FSM stays in WAIT_PRESS.
REQ-040 TIMEOUT_CYCLES=20, start with no press -> fail pulse on cycle 21 after start; press 4'b0011 in a separate run -> fail.
REQ-041 reset_n pulsed low during WAIT_RELEASE at check_round=1 -> all outputs 0 asynchronously; later start with round_len=0 -> busy stays 0.
REQ-042 round_len=32 with all segment entries 3'b010, 32 correct bit2 presses -> check_round reaches 31 and a single pass pulse follows.
